// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a combinational-read instruction memory and
// buffers fetched {pc, instr} pairs in a 2-entry in-order queue for decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;

    logic deq;
    logic fetch;

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = head_pc_q;
    assign out_instr = head_instr_q;

    assign deq   = out_valid & out_ready;
    assign fetch = ~redirect_valid & ((count_q < 2'd2) | deq);

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        if (redirect_valid) begin
            // Redirect wins: drop everything queued and restart on a word boundary.
            count_d    = 2'd0;
            fetch_pc_d = redirect_target & 32'hFFFF_FFFC;
        end else begin
            if (fetch) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            unique case ({fetch, deq})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d    = fetch_pc_q;
                        head_instr_d = imem_data;
                    end else begin
                        tail_pc_d    = fetch_pc_q;
                        tail_instr_d = imem_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    count_d      = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = fetch_pc_q;
                        tail_instr_d = imem_data;
                    end else begin
                        head_pc_d    = fetch_pc_q;
                        head_instr_d = imem_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            count_q      <= 2'd0;
            head_pc_q    <= 32'd0;
            head_instr_q <= 32'd0;
            tail_pc_q    <= 32'd0;
            tail_instr_q <= 32'd0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

endmodule
